// File: rtl/bin_to_bcd_100_if.sv
// Handshake and result bundle for bin_to_bcd_100.
// The seven-segment fields exist only when BIN_TO_BCD_100_SEG_EN is defined.
interface bin_to_bcd_100_if;
  logic       START;
  logic [6:0] BIN;
  logic [3:0] TENS;
  logic [3:0] UNITS;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
`ifdef BIN_TO_BCD_100_SEG_EN
  logic [6:0] SEG_T;
  logic [6:0] SEG_U;

  modport master (output START, BIN,
                  input  TENS, UNITS, BUSY, DONE, ERR, SEG_T, SEG_U);
  modport slave  (input  START, BIN,
                  output TENS, UNITS, BUSY, DONE, ERR, SEG_T, SEG_U);
`else
  modport master (output START, BIN,
                  input  TENS, UNITS, BUSY, DONE, ERR);
  modport slave  (input  START, BIN,
                  output TENS, UNITS, BUSY, DONE, ERR);
`endif
endinterface

// File: rtl/bin_to_bcd_100.sv
// Sequential 7-bit binary to two-digit BCD converter (double dabble, one bit per cycle).
// Optional seven-segment outputs are enabled by defining BIN_TO_BCD_100_SEG_EN.
module bin_to_bcd_100 #(
  parameter logic [3:0] ERR_CODE = 4'hF
) (
  input logic            CLK,
  input logic            RESET,
  bin_to_bcd_100_if.slave bus
);

  localparam int unsigned BIN_W = 7;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [DIG_W-1:0]   units_q, tens_q, hund_q;
  logic [DIG_W-1:0]   units_d, tens_d, hund_d;
  logic [DIG_W-1:0]   units_adj, tens_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIG_W-1:0]   tens_out_q, units_out_q;
  logic               busy_q, done_q, err_q;

  // One double-dabble step; the hundreds digit never exceeds 1, so it needs no add-3.
  always_comb begin
    units_adj = (units_q >= DIG_W'(5)) ? units_q + DIG_W'(3) : units_q;
    tens_adj  = (tens_q  >= DIG_W'(5)) ? tens_q  + DIG_W'(3) : tens_q;
    units_d   = {units_adj[DIG_W-2:0], bin_q[BIN_W-1]};
    tens_d    = {tens_adj[DIG_W-2:0],  units_adj[DIG_W-1]};
    hund_d    = {hund_q[DIG_W-2:0],    tens_adj[DIG_W-1]};
    bin_d     = {bin_q[BIN_W-2:0], 1'b0};
  end

`ifdef BIN_TO_BCD_100_SEG_EN
  logic [6:0] seg_t_q, seg_u_q;

  // Active-high segments, bit order gfedcba; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [DIG_W-1:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign bus.SEG_T = seg_t_q;
  assign bus.SEG_U = seg_u_q;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      units_q     <= '0;
      tens_q      <= '0;
      hund_q      <= '0;
      cnt_q       <= '0;
      tens_out_q  <= '0;
      units_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef BIN_TO_BCD_100_SEG_EN
      seg_t_q     <= '0;
      seg_u_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.START) begin
            bin_q   <= bus.BIN;
            units_q <= '0;
            tens_q  <= '0;
            hund_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q   <= bin_d;
          units_q <= units_d;
          tens_q  <= tens_d;
          hund_q  <= hund_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= FINISH;
        end
        FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
          // Any hundreds content means the input was above 99.
          if (hund_q != '0) begin
            tens_out_q  <= ERR_CODE;
            units_out_q <= ERR_CODE;
            err_q       <= 1'b1;
`ifdef BIN_TO_BCD_100_SEG_EN
            seg_t_q     <= '0;
            seg_u_q     <= '0;
`endif
          end else begin
            tens_out_q  <= tens_q;
            units_out_q <= units_q;
            err_q       <= 1'b0;
`ifdef BIN_TO_BCD_100_SEG_EN
            seg_t_q     <= seg7(tens_q);
            seg_u_q     <= seg7(units_q);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.TENS  = tens_out_q;
  assign bus.UNITS = units_out_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.ERR   = err_q;

endmodule

// File: tb/tb_bin_to_bcd_100.sv
// Bench for bin_to_bcd_100: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_bin_to_bcd_100;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  bin_to_bcd_100_if bus ();

  bin_to_bcd_100 #(.ERR_CODE(4'hF)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a conversion finishes 8 edges after acceptance with value/10, value%10.
  int         m_rem = 0;
  int         m_val = 0;
  logic [3:0] m_t = '0, m_u = '0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_rem = 0; m_t = '0; m_u = '0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else if (m_rem == 0) begin
      m_done = 1'b0;
      if (bus.START === 1'b1) begin
        m_val  = int'(bus.BIN);
        m_rem  = 8;
        m_busy = 1'b1;
      end
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        if (m_val > 99) begin
          m_t = 4'hF; m_u = 4'hF; m_err = 1'b1;
        end else begin
          m_t = 4'(m_val / 10); m_u = 4'(m_val % 10); m_err = 1'b0;
        end
      end
    end
    #1;
    check("cycle {tens,units,busy,done,err}",
          32'({bus.TENS, bus.UNITS, bus.BUSY, bus.DONE, bus.ERR}),
          32'({m_t, m_u, m_busy, m_done, m_err}));
  end

  // Present START/BIN before an edge and release after it; returns BUSY just after acceptance.
  task automatic go(input logic [6:0] b, output logic busy0);
    @(negedge CLK);
    bus.START = 1'b1;
    bus.BIN   = b;
    @(posedge CLK);
    #1;
    busy0     = bus.BUSY;
    bus.START = 1'b0;
    bus.BIN   = 7'($urandom);
  endtask

  // Edges from acceptance until DONE is seen (0 on timeout) and BUSY cycles before it.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK);
      #1;
      if (bus.DONE === 1'b1) begin
        n = i;
        break;
      end
      if (bus.BUSY === 1'b1) nb++;
    end
  endtask

  task automatic conv(input logic [6:0] b, input logic [3:0] et, input logic [3:0] eu,
                      input logic ee, input string name);
    logic busy0;
    int   n, nb;
    go(b, busy0);
    wait_done(n, nb);
    check({name, " latency"}, 32'(n), 32'd8);
    check({name, " busy cycles"}, 32'(nb + int'(busy0)), 32'd8);
    check({name, " result"}, 32'({bus.TENS, bus.UNITS, bus.ERR}), 32'({et, eu, ee}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic busy0;
    int   n, nb, dones;
    logic [10:0] hit;

    bus.START = 1'b0;
    bus.BIN   = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset outputs", 32'({bus.TENS, bus.UNITS, bus.BUSY, bus.DONE, bus.ERR}), 32'd0);

    // First edge with RESET low accepts START.
    @(negedge CLK);
    RESET     = 1'b0;
    bus.START = 1'b1;
    bus.BIN   = 7'd57;
    @(posedge CLK);
    #1;
    busy0     = bus.BUSY;
    bus.START = 1'b0;
    bus.BIN   = 7'd3;
    wait_done(n, nb);
    check("57 latency", 32'(n), 32'd8);
    check("57 busy cycles", 32'(nb + int'(busy0)), 32'd8);
    check("57 result", 32'({bus.TENS, bus.UNITS, bus.ERR}), 32'({4'd5, 4'd7, 1'b0}));

    // Back-to-back: second START presented during the DONE cycle.
    conv(7'd0, 4'd0, 4'd0, 1'b0, "0");
    bus.START = 1'b1;
    bus.BIN   = 7'd99;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    wait_done(n, nb);
    check("99 done spacing", 32'(n + 1), 32'd9);
    check("99 result", 32'({bus.TENS, bus.UNITS, bus.ERR}), 32'({4'd9, 4'd9, 1'b0}));

    conv(7'd100, 4'hF, 4'hF, 1'b1, "100");
    conv(7'd127, 4'hF, 4'hF, 1'b1, "127");
    conv(7'd10,  4'd1, 4'd0, 1'b0, "10");

    // START pulses during a running conversion are ignored.
    go(7'd42, busy0);
    dones = 0;
    hit   = '0;
    for (int i = 1; i <= 12; i++) begin
      bus.START = (i == 3 || i == 7);
      bus.BIN   = 7'd88;
      @(posedge CLK);
      #1;
      if (bus.DONE === 1'b1) begin
        dones++;
        hit = {bus.TENS, bus.UNITS, bus.ERR, 2'b00};
      end
    end
    bus.START = 1'b0;
    check("42 done count", 32'(dones), 32'd1);
    check("42 result", 32'(hit), 32'({4'd4, 4'd2, 1'b0, 2'b00}));

    // Reset mid-conversion aborts without DONE.
    go(7'd63, busy0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("abort outputs", 32'({bus.TENS, bus.UNITS, bus.BUSY, bus.DONE, bus.ERR}), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      if (bus.DONE === 1'b1) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    conv(7'd31, 4'd3, 4'd1, 1'b0, "31");

`ifdef BIN_TO_BCD_100_SEG_EN
    conv(7'd81, 4'd8, 4'd1, 1'b0, "81");
    check("81 segments", 32'({bus.SEG_T, bus.SEG_U}), 32'({7'b1111111, 7'b0000110}));
    conv(7'd120, 4'hF, 4'hF, 1'b1, "120");
    check("120 segments", 32'({bus.SEG_T, bus.SEG_U}), 32'd0);
`endif

    // Randomized traffic; the per-cycle model compare does the checking.
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      RESET     = ($urandom_range(0, 149) == 0);
      bus.START = ($urandom_range(0, 2) == 0);
      bus.BIN   = 7'($urandom);
    end
    @(negedge CLK);
    RESET     = 1'b0;
    bus.START = 1'b0;
    repeat (12) @(posedge CLK);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_100.md
BIN_TO_BCD_100 -- requirements
Module: bin_to_bcd_100

Interface
REQ-001 Parameter: ERR_CODE, default 4'hF, digit value driven on TENS and UNITS for out-of-range input.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: START  input  1  conversion request; sampled only in IDLE.
REQ-005 Port: BIN  input  7  binary value to convert; legal range 0..99; sampled with accepted START.
REQ-006 Port: TENS  output  4  registered BCD tens digit of last completed conversion.
REQ-007 Port: UNITS  output  4  registered BCD units digit of last completed conversion.
REQ-008 Port: BUSY  output  1  high while a conversion is in progress.
REQ-009 Port: DONE  output  1  one-cycle pulse marking TENS/UNITS/ERR update.
REQ-010 Port: ERR  output  1  high when last completed conversion had BIN > 99.

Function
REQ-011 The block SHALL convert BIN to two BCD digits by iterative shift-and-add-3 (double dabble), one bit per cycle, MSB first.
REQ-012 The FSM SHALL have states IDLE, SHIFT, FINISH; IDLE->SHIFT on START=1; SHIFT->FINISH after the 7th shift; FINISH->IDLE unconditionally.
REQ-013 On the edge accepting START (edge k), the block SHALL capture BIN, clear internal digit registers, clear bit counter, and set BUSY=1.
REQ-014 On edges k+1..k+7 the block SHALL add 3 to any internal digit >= 5, then shift left one bit, consuming one BIN bit per edge.
REQ-015 On edge k+8 the block SHALL load TENS/UNITS, set ERR, pulse DONE=1 for exactly one cycle, and clear BUSY; latency START-accept to DONE = 8 cycles.
REQ-016 BUSY SHALL be 1 from edge k through the cycle before DONE rises; BUSY and DONE SHALL never be 1 together.
REQ-017 START while BUSY=1 SHALL be ignored with no effect on the running conversion.
REQ-018 START high in the cycle DONE=1 SHALL be accepted (state is IDLE); sustained START gives one result every 9 cycles.
REQ-019 If captured BIN > 99, the conversion SHALL run its full 8 cycles; at completion TENS=UNITS=ERR_CODE and ERR=1.
REQ-020 If captured BIN <= 99, ERR SHALL be 0 at completion.
REQ-021 TENS, UNITS, ERR SHALL hold their values between completions; BIN changes after capture SHALL have no effect.
REQ-022 Internal hundreds-digit bits SHALL be used only for out-of-range detection and SHALL never be output.

Reset
REQ-023 With RESET=1 at an edge, state SHALL be IDLE and TENS=0, UNITS=0, BUSY=0, DONE=0, ERR=0 after that edge.
REQ-024 RESET SHALL override START and abort any in-progress conversion without producing DONE.
REQ-025 The first START accepted SHALL be at the first edge with RESET=0.

Configuration
REQ-026 Macro BIN_TO_BCD_100_SEG_EN defined: ports SEG_T[6:0] and SEG_U[6:0] SHALL exist, active-high segments ordered gfedcba, decoded from TENS/UNITS and updated on the same edge; ERR_CODE digits and reset SHALL drive 7'b0000000.
REQ-027 Macro not defined: SEG_T/SEG_U ports and decode logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset, START with BIN=57 -> DONE at edge k+8, TENS=5, UNITS=7, ERR=0, BUSY high 8 cycles.
REQ-029 BIN=0 then BIN=99 back-to-back (second START in DONE cycle) -> 0/0 then 9/9, DONEs 9 cycles apart.
REQ-030 BIN=100 and BIN=127 -> TENS=UNITS=4'hF, ERR=1; following BIN=10 -> 1/0, ERR=0.
REQ-031 BIN=42 start, then START pulses with BIN=88 at edges k+3 and k+7 -> single DONE with 4/2.
REQ-032 BIN=63 start, RESET at edge k+4 -> no DONE, all outputs 0; new START BIN=31 -> 3/1 after 8 cycles.
REQ-033 With BIN_TO_BCD_100_SEG_EN: BIN=81 -> SEG_T=7'b1111111, SEG_U=7'b0000110; BIN=120 -> both 7'b0000000.
